// File: rtl/d20_pkg.sv
// Shared types for the d20 roll scheduler: FSM states, die bounds and the response bundle.
package d20_pkg;

  typedef enum logic [1:0] {IDLE, READ, EVAL, RESP} state_t;

  localparam logic [4:0] DIE_MIN = 5'd1;
  localparam logic [4:0] DIE_MAX = 5'd20;

  // Width of the final field carried in the response bundle; matches the default NUM_BITS.
  localparam int FINAL_W = 8;

  typedef struct packed {
    logic [4:0]         die;
    logic [FINAL_W-1:0] final_val;
    logic               hit;
    logic               crit;
    logic               fumble;
    logic               err;
  } roll_rsp_t;

  function automatic logic die_in_range(input logic [4:0] d);
    return (d >= DIE_MIN) && (d <= DIE_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_i, wrapping.
// Zero latency; no state, so backpressure is whatever the caller does with gnt_valid_o.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_id_o
);

  int idx;

  // Scan from the farthest slot down to the nearest so the nearest set bit wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    idx         = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_i) + k) % N;
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/roll_scheduler.sv
// Arbitrates d20 rolls over one entropy memory, rejection-samples words to 1..20, applies mod/target.
// Best case: ack at t, response valid at t+3; response held stable until rsp_ready, no grants meanwhile.
module roll_scheduler
  import d20_pkg::*;
#(
  parameter int NUM_BITS  = 8,
  parameter int N_REQ     = 4,
  parameter int DEPTH     = 32,
  parameter int MAX_TRIES = 32,
  localparam int IDW = $clog2(N_REQ),
  localparam int PW  = $clog2(DEPTH),
  localparam int TW  = $clog2(MAX_TRIES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*NUM_BITS-1:0] req_mod,
  input  logic [N_REQ*NUM_BITS-1:0] req_target,
  output logic [N_REQ-1:0]          req_ack,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [4:0]                rsp_die,
  output logic [NUM_BITS-1:0]       rsp_final,
  output logic                      rsp_hit,
  output logic                      rsp_crit,
  output logic                      rsp_fumble,
  output logic                      rsp_err,
  output logic                      mem_rd_en,
  output logic [31:0]               mem_addr,
  input  logic [4:0]                mem_data,
  input  logic                      mem_wr_active,
  output logic                      busy
);

  state_t                     state_q, state_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [IDW-1:0]             rr_last_q, rr_last_d;
  logic [IDW-1:0]             id_q, id_d;
  logic [TW-1:0]              tries_q, tries_d, tries_inc;
  logic signed [NUM_BITS-1:0] mod_q, mod_d, tgt_q, tgt_d, final_sum;
  logic [4:0]                 die_q, die_d;
  logic                       err_q, err_d;
  logic                       gnt_valid, die_ok, tries_out;
  logic [IDW-1:0]             gnt_id;
  roll_rsp_t                  rsp;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i       (req),
    .last_i      (rr_last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  assign die_ok    = die_in_range(mem_data);
  assign tries_inc = tries_q + 1'b1;
  assign tries_out = (tries_inc == TW'(MAX_TRIES));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = READ;
      READ:    if (!mem_wr_active) state_d = EVAL;
      EVAL:    state_d = (die_ok || tries_out) ? RESP : READ;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every evaluated word is consumed, accepted or not, so rd_ptr advances on each EVAL.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    rr_last_d = rr_last_q;
    id_d      = id_q;
    tries_d   = tries_q;
    mod_d     = mod_q;
    tgt_d     = tgt_q;
    die_d     = die_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (gnt_valid) begin
        id_d      = gnt_id;
        rr_last_d = gnt_id;
        tries_d   = '0;
        die_d     = '0;
        err_d     = 1'b0;
        mod_d     = req_mod[int'(gnt_id)*NUM_BITS +: NUM_BITS];
        tgt_d     = req_target[int'(gnt_id)*NUM_BITS +: NUM_BITS];
      end
      EVAL: begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (die_ok) begin
          die_d = mem_data;
        end else begin
          tries_d = tries_inc;
          err_d   = tries_out;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      rr_last_q <= IDW'(N_REQ - 1);
      id_q      <= '0;
      tries_q   <= '0;
      mod_q     <= '0;
      tgt_q     <= '0;
      die_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      rr_last_q <= rr_last_d;
      id_q      <= id_d;
      tries_q   <= tries_d;
      mod_q     <= mod_d;
      tgt_q     <= tgt_d;
      die_q     <= die_d;
      err_q     <= err_d;
    end
  end

  assign final_sum = mod_q + NUM_BITS'(die_q);

  always_comb begin
    rsp = '0;
    if (!err_q) begin
      rsp.die       = die_q;
      rsp.final_val = FINAL_W'(final_sum);
      rsp.hit       = (final_sum >= tgt_q);
      rsp.crit      = (die_q == DIE_MAX);
      rsp.fumble    = (die_q == DIE_MIN);
    end
    rsp.err = err_q;
  end

  always_comb begin
    req_ack    = '0;
    rsp_valid  = 1'b0;
    rsp_id     = '0;
    rsp_die    = '0;
    rsp_final  = '0;
    rsp_hit    = 1'b0;
    rsp_crit   = 1'b0;
    rsp_fumble = 1'b0;
    rsp_err    = 1'b0;
    busy       = (state_q != IDLE);
    mem_rd_en  = (state_q == READ);
    mem_addr   = 32'(rd_ptr_q);
    if (state_q == IDLE && gnt_valid && !reset) req_ack = N_REQ'(1) << gnt_id;
    if (state_q == RESP) begin
      rsp_valid  = 1'b1;
      rsp_id     = id_q;
      rsp_die    = rsp.die;
      rsp_final  = NUM_BITS'(rsp.final_val);
      rsp_hit    = rsp.hit;
      rsp_crit   = rsp.crit;
      rsp_fumble = rsp.fumble;
      rsp_err    = rsp.err;
    end
  end

endmodule

// File: tb/tb_roll_scheduler.sv
// Bench for roll_scheduler: directed rolls plus a per-cycle reference model of grants and responses.
module tb_roll_scheduler;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        req = '0;
  logic signed [7:0] bm [4];
  logic signed [7:0] bt [4];
  logic [31:0]       req_mod, req_target;
  logic [3:0]        req_ack;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [1:0]        rsp_id;
  logic [4:0]        rsp_die;
  logic [7:0]        rsp_final;
  logic              rsp_hit, rsp_crit, rsp_fumble, rsp_err;
  logic              mem_rd_en;
  logic [31:0]       mem_addr;
  logic [4:0]        mem_data = '0;
  logic              mem_wr_active = 1'b0;
  logic              busy;

  logic [4:0] mem [32];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign req_mod    = {bm[3], bm[2], bm[1], bm[0]};
  assign req_target = {bt[3], bt[2], bt[1], bt[0]};

  always @(posedge clk) if (mem_rd_en && !mem_wr_active) mem_data <= mem[mem_addr[4:0]];

  roll_scheduler dut (
    .clk(clk), .reset(reset), .req(req), .req_mod(req_mod), .req_target(req_target),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_die(rsp_die), .rsp_final(rsp_final), .rsp_hit(rsp_hit), .rsp_crit(rsp_crit),
    .rsp_fumble(rsp_fumble), .rsp_err(rsp_err), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_wr_active(mem_wr_active), .busy(busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a pending roll is resolved entirely at grant time from the memory image.
  int         m_ptr = 0;
  int         m_last = 3;
  bit         m_busy = 0;
  int         m_g;
  logic [3:0] m_ea;
  int         e_id;
  logic [4:0] e_die;
  logic [7:0] e_fin;
  bit         e_hit, e_crit, e_fum, e_err;

  function automatic int m_grant(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic m_predict(input int id);
    int d;
    logic signed [7:0] f;
    d = 0;
    e_err = 1;
    for (int t = 0; t < 32; t++) begin
      d = int'(mem[m_ptr]);
      m_ptr = (m_ptr + 1) % 32;
      if (d >= 1 && d <= 20) begin
        e_err = 0;
        break;
      end
    end
    e_id = id;
    if (e_err) begin
      e_die = 0; e_fin = 0; e_hit = 0; e_crit = 0; e_fum = 0;
    end else begin
      f = 8'(d + int'(bm[id]));
      e_die = 5'(d);
      e_fin = f;
      e_hit = (f >= bt[id]);
      e_crit = (d == 20);
      e_fum = (d == 1);
    end
  endtask

  always begin
    @(negedge clk);
    #3;
    if (reset) begin
      m_ptr = 0; m_last = 3; m_busy = 0;
    end else begin
      m_g  = m_grant(req, m_last);
      m_ea = (!m_busy && m_g >= 0) ? 4'(1 << m_g) : 4'h0;
      check("mon_ack", req_ack, m_ea);
      check("mon_busy", busy, m_busy);
      if (m_busy && rsp_valid) begin
        check("mon_id", rsp_id, e_id);
        check("mon_die", rsp_die, e_die);
        check("mon_final", rsp_final, e_fin);
        check("mon_hit", rsp_hit, e_hit);
        check("mon_crit", rsp_crit, e_crit);
        check("mon_fumble", rsp_fumble, e_fum);
        check("mon_err", rsp_err, e_err);
        if (rsp_ready) m_busy = 0;
      end
      if (m_ea != 4'h0) begin
        m_predict(m_g);
        m_last = m_g;
        m_busy = 1;
      end
    end
  end

  int         w_lat, w_rd;
  logic [1:0] c_id;
  logic [4:0] c_die;
  logic [7:0] c_fin;
  logic       c_hit, c_crit, c_fum, c_err;

  task automatic wait_rsp(input bit keep, input int stall, input int budget);
    bit done;
    done = 0;
    w_lat = 0;
    w_rd = 0;
    while (!done) begin
      @(negedge clk);
      if (!keep) req = '0;
      mem_wr_active = (w_lat < stall);
      #3;
      w_lat++;
      w_rd += int'(mem_rd_en);
      if (rsp_valid) begin
        done = 1;
      end else if (w_lat >= budget) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_timeout: no rsp_valid after %0d cycles, expected within %0d", w_lat, budget);
        done = 1;
      end
    end
    c_id = rsp_id; c_die = rsp_die; c_fin = rsp_final;
    c_hit = rsp_hit; c_crit = rsp_crit; c_fum = rsp_fumble; c_err = rsp_err;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; req = '0; mem_wr_active = 0; rsp_ready = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic roll(input logic [3:0] r, input int exp_id, input string nm, input int budget);
    @(negedge clk);
    req = r;
    #3;
    check({nm, "_ack"}, req_ack, 32'(1 << exp_id));
    wait_rsp(0, 0, budget);
  endtask

  int exp_g [5];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 5'd0;
    for (int i = 0; i < 4; i++) begin bm[i] = 8'sd0; bt[i] = 8'sd0; end
    exp_g = '{0, 1, 2, 3, 0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    #3;
    check("rst_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_ack", req_ack, 0);
    check("rst_die", rsp_die, 0);

    // 1: single roll, best-case latency
    mem[0] = 5'd7; bm[2] = 8'sd3; bt[2] = 8'sd10;
    roll(4'b0100, 2, "t1", 20);
    check("t1_lat", w_lat, 3);
    check("t1_id", c_id, 2);
    check("t1_die", c_die, 7);
    check("t1_final", c_fin, 10);
    check("t1_hit", c_hit, 1);

    // 2: rejected words 0 and 25 before 20
    do_reset();
    mem[0] = 5'd0; mem[1] = 5'd25; mem[2] = 5'd20;
    roll(4'b0001, 0, "t2", 30);
    check("t2_reads", w_rd, 3);
    check("t2_lat", w_lat, 7);
    check("t2_die", c_die, 20);
    check("t2_crit", c_crit, 1);
    @(negedge clk); #3;
    check("t2_addr", mem_addr, 3);

    // 3: every word rejected -> error after MAX_TRIES, pointer wraps
    do_reset();
    for (int i = 0; i < 32; i++) mem[i] = 5'd31;
    roll(4'b0010, 1, "t3", 200);
    check("t3_err", c_err, 1);
    check("t3_die", c_die, 0);
    check("t3_final", c_fin, 0);
    check("t3_hit", c_hit, 0);
    check("t3_reads", w_rd, 32);
    check("t3_lat", w_lat, 65);
    @(negedge clk); #3;
    check("t3_addr", mem_addr, 0);

    // 4: all requesters held -> round-robin order
    do_reset();
    for (int i = 0; i < 32; i++) mem[i] = 5'((i % 20) + 1);
    for (int i = 0; i < 4; i++) begin bm[i] = 8'(i); bt[i] = 8'sd10; end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req = 4'hF;
      #3;
      check("t4_grant", req_ack, 32'(1 << exp_g[k]));
      wait_rsp(1, 0, 20);
      check("t4_id", c_id, exp_g[k]);
    end

    // 5: consumer stalls; response must hold and no grant may occur
    @(negedge clk);
    req = 4'b1000; rsp_ready = 0;
    #3;
    check("t5_ack", req_ack, 4'b1000);
    wait_rsp(0, 0, 20);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req = 4'b0001;
      #3;
      check("t5_valid", rsp_valid, 1);
      check("t5_die", rsp_die, c_die);
      check("t5_final", rsp_final, c_fin);
      check("t5_id", rsp_id, 3);
      check("t5_no_ack", req_ack, 0);
    end
    @(negedge clk);
    req = '0; rsp_ready = 1;
    #3;
    check("t5_release", rsp_valid, 1);
    @(negedge clk); #3;
    check("t5_drained", rsp_valid, 0);

    // 6: memory write collisions stall READ without consuming tries
    @(negedge clk);
    req = 4'b0010;
    #3;
    check("t6_ack", req_ack, 4'b0010);
    wait_rsp(0, 3, 30);
    check("t6_lat", w_lat, 6);
    check("t6_reads", w_rd, 4);
    check("t6_err", c_err, 0);

    // 7: negative modifier and two's-complement wrap
    do_reset();
    mem[0] = 5'd1; mem[1] = 5'd5;
    bm[0] = -8'sd8; bt[0] = 8'sd0;
    bm[1] = 8'sd127; bt[1] = -8'sd128;
    roll(4'b0001, 0, "t7a", 20);
    check("t7a_die", c_die, 1);
    check("t7a_final", c_fin, 32'hF9);
    check("t7a_fumble", c_fum, 1);
    check("t7a_hit", c_hit, 0);
    roll(4'b0010, 1, "t7b", 20);
    check("t7b_die", c_die, 5);
    check("t7b_final", c_fin, 32'h84);
    check("t7b_hit", c_hit, 1);
    check("t7b_crit", c_crit, 0);

    // 8: reset during EVAL drops the roll and restores the pointer
    do_reset();
    mem[0] = 5'd31; mem[1] = 5'd5;
    @(negedge clk);
    req = 4'b0100;
    #3;
    check("t8_ack", req_ack, 4'b0100);
    @(negedge clk);
    req = '0;
    #3;
    check("t8_read", mem_rd_en, 1);
    @(negedge clk);
    reset = 1;
    #3;
    check("t8_in_eval", busy, 1);
    @(negedge clk);
    reset = 0;
    #3;
    check("t8_busy", busy, 0);
    check("t8_valid", rsp_valid, 0);
    check("t8_addr", mem_addr, 0);
    check("t8_rd_en", mem_rd_en, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
